poly_voice_allocator: RTL and testbench

Event-driven, parametrised voice allocator that replaces the combinational key-matrix scan with per-voice state. It consumes PS/2 make/break events (Set 2 scancodes), maps them to notes C3..E4, and assigns each note to one of NUM_VOICES voice slots with stable slot ownership. It holds each note until release and exposes per-voice tick period, gate and 7-segment glyph to the oscillator bank and display driver.

---
 rtl/poly_voice_allocator_if.sv | 15 +
 rtl/poly_voice_allocator.sv | 228 ++++++++++++++++++++++
 tb/tb_poly_voice_allocator.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/poly_voice_allocator_if.sv
// rtl/poly_voice_allocator_if.sv - key-event handshake bundle for poly_voice_allocator
// Ports (signals):
//   ev_valid  key event present (master -> slave)
//   ev_ready  allocator can accept an event (slave -> master)
//   ev_code   PS/2 Set 2 scancode (master -> slave)
//   ev_break  1 = key release, 0 = key press (master -> slave)
interface poly_voice_allocator_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_break;

  modport master (output ev_valid, output ev_code, output ev_break, input ev_ready);
  modport slave  (input ev_valid, input ev_code, input ev_break, output ev_ready);
endinterface

// File: rtl/poly_voice_allocator.sv
// rtl/poly_voice_allocator.sv - event-driven polyphonic voice allocator with stable slot ownership
// Optional feature macro: VOICE_STEAL_EN (press on a full bank steals the oldest voice).
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   all_off      synchronous panic, releases every voice and aborts the in-flight event
//   ev           key-event handshake (slave side of poly_voice_allocator_if)
//   gate         per-voice note-active flags
//   ticks_flat   voice i tick period at [i*TICK_W +: TICK_W]
//   seg_flat     voice i active-low glyph (gfedcba) at [i*7 +: 7]
//   voice_count  number of gated voices
//   steal_pulse  one-cycle strobe when a voice is stolen
module poly_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int TICK_W     = 24,
  parameter int AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         all_off,
  poly_voice_allocator_if.slave        ev,
  output logic [NUM_VOICES-1:0]        gate,
  output logic [NUM_VOICES*TICK_W-1:0] ticks_flat,
  output logic [NUM_VOICES*7-1:0]      seg_flat,
  output logic [4:0]                   voice_count,
  output logic                         steal_pulse
);

`ifdef VOICE_STEAL_EN
  localparam bit STEAL_EN = 1'b1;
`else
  localparam bit STEAL_EN = 1'b0;
`endif

  localparam int SW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [SW-1:0]    LAST    = SW'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_G     = 7'b1000010;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;

  typedef enum logic [1:0] {IDLE, LOOKUP, SCAN, COMMIT} state_t;
  state_t state;

  logic [7:0]       code_q;
  logic             brk_q;
  logic [4:0]       cur_note;
  logic [10:0]      cur_tick;
  logic [6:0]       cur_seg;
  logic [SW-1:0]    scan_idx, match_idx, free_idx, old_idx;
  logic             found_match, found_free, found_old;
  logic [AGE_W-1:0] old_age;
  logic [4:0]       note_q [NUM_VOICES];
  logic [AGE_W-1:0] age_q  [NUM_VOICES];

  logic             lk_valid;
  logic [4:0]       lk_note;
  logic [10:0]      lk_tick;
  logic [6:0]       lk_seg;
  logic             do_press, do_steal, do_release;
  logic [SW-1:0]    sel_idx;
  logic [NUM_VOICES-1:0] gate_nxt;

  assign ev.ev_ready = (state == IDLE);

  function automatic logic [4:0] popcount(input logic [NUM_VOICES-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < NUM_VOICES; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  always_comb begin
    lk_valid = 1'b1;
    lk_note  = 5'd0;
    lk_tick  = 11'd0;
    lk_seg   = SEG_BLANK;
    case (code_q)
      8'h1C: begin lk_note = 5'd0;  lk_tick = 11'd1493; lk_seg = SEG_C; end
      8'h1D: begin lk_note = 5'd1;  lk_tick = 11'd1409; lk_seg = SEG_C; end
      8'h1B: begin lk_note = 5'd2;  lk_tick = 11'd1330; lk_seg = SEG_D; end
      8'h24: begin lk_note = 5'd3;  lk_tick = 11'd1256; lk_seg = SEG_D; end
      8'h23: begin lk_note = 5'd4;  lk_tick = 11'd1185; lk_seg = SEG_E; end
      8'h2B: begin lk_note = 5'd5;  lk_tick = 11'd1119; lk_seg = SEG_F; end
      8'h2C: begin lk_note = 5'd6;  lk_tick = 11'd1056; lk_seg = SEG_F; end
      8'h34: begin lk_note = 5'd7;  lk_tick = 11'd996;  lk_seg = SEG_G; end
      8'h35: begin lk_note = 5'd8;  lk_tick = 11'd941;  lk_seg = SEG_G; end
      8'h33: begin lk_note = 5'd9;  lk_tick = 11'd888;  lk_seg = SEG_A; end
      8'h3C: begin lk_note = 5'd10; lk_tick = 11'd838;  lk_seg = SEG_A; end
      8'h3B: begin lk_note = 5'd11; lk_tick = 11'd791;  lk_seg = SEG_B; end
      8'h42: begin lk_note = 5'd12; lk_tick = 11'd747;  lk_seg = SEG_C; end
      8'h44: begin lk_note = 5'd13; lk_tick = 11'd705;  lk_seg = SEG_C; end
      8'h4B: begin lk_note = 5'd14; lk_tick = 11'd665;  lk_seg = SEG_D; end
      8'h4D: begin lk_note = 5'd15; lk_tick = 11'd628;  lk_seg = SEG_D; end
      8'h4C: begin lk_note = 5'd16; lk_tick = 11'd593;  lk_seg = SEG_E; end
      default: lk_valid = 1'b0;
    endcase
  end

  // Commit decision: a held note only refreshes its age; otherwise take the
  // lowest free slot, and only when none is free fall back to stealing.
  always_comb begin
    do_steal   = (state == COMMIT) && !brk_q && !found_match && !found_free && STEAL_EN;
    do_press   = (state == COMMIT) && !brk_q && (found_match || found_free || do_steal);
    do_release = (state == COMMIT) && brk_q && found_match;
    sel_idx    = found_match ? match_idx : (found_free ? free_idx : old_idx);
    gate_nxt   = gate;
    if (do_press)   gate_nxt[sel_idx]   = 1'b1;
    if (do_release) gate_nxt[match_idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      code_q      <= 8'd0;
      brk_q       <= 1'b0;
      cur_note    <= 5'd0;
      cur_tick    <= 11'd0;
      cur_seg     <= SEG_BLANK;
      scan_idx    <= '0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      found_match <= 1'b0;
      found_free  <= 1'b0;
      found_old   <= 1'b0;
      old_age     <= '0;
      gate        <= '0;
      ticks_flat  <= '0;
      seg_flat    <= {NUM_VOICES{SEG_BLANK}};
      voice_count <= 5'd0;
      steal_pulse <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= 5'd0;
        age_q[i]  <= '0;
      end
    end else if (all_off) begin
      // Panic wins over everything, including an event presented this cycle.
      state       <= IDLE;
      gate        <= '0;
      ticks_flat  <= '0;
      seg_flat    <= {NUM_VOICES{SEG_BLANK}};
      voice_count <= 5'd0;
      steal_pulse <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= 5'd0;
        age_q[i]  <= '0;
      end
    end else begin
      steal_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (ev.ev_valid) begin
            code_q <= ev.ev_code;
            brk_q  <= ev.ev_break;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lk_valid) begin
            cur_note    <= lk_note;
            cur_tick    <= lk_tick;
            cur_seg     <= lk_seg;
            scan_idx    <= '0;
            found_match <= 1'b0;
            found_free  <= 1'b0;
            found_old   <= 1'b0;
            state       <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          // Ascending scan with first-hit/strictly-greater updates keeps the
          // lowest index on ties.
          if (gate[scan_idx] && note_q[scan_idx] == cur_note && !found_match) begin
            found_match <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!gate[scan_idx] && !found_free) begin
            found_free <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (gate[scan_idx] && (!found_old || age_q[scan_idx] > old_age)) begin
            found_old <= 1'b1;
            old_idx   <= scan_idx;
            old_age   <= age_q[scan_idx];
          end
          if (scan_idx == LAST) state <= COMMIT;
          else scan_idx <= scan_idx + 1'b1;
        end
        COMMIT: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (do_press) begin
              if (sel_idx == SW'(i)) begin
                age_q[i] <= '0;
                if (!found_match) begin
                  note_q[i]                      <= cur_note;
                  ticks_flat[i*TICK_W +: TICK_W] <= TICK_W'(cur_tick);
                  seg_flat[i*7 +: 7]             <= cur_seg;
                end
              end else if (gate[i] && age_q[i] != AGE_MAX) begin
                age_q[i] <= age_q[i] + AGE_W'(1);
              end
            end
            if (do_release && match_idx == SW'(i)) begin
              age_q[i]                       <= '0;
              ticks_flat[i*TICK_W +: TICK_W] <= '0;
              seg_flat[i*7 +: 7]             <= SEG_BLANK;
            end
          end
          gate        <= gate_nxt;
          voice_count <= popcount(gate_nxt);
          steal_pulse <= do_steal;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_voice_allocator.sv
// tb/tb_poly_voice_allocator.sv - self-checking bench for poly_voice_allocator
// Ports: none (drives clk, rst, all_off and the event interface of the DUT).
module tb_poly_voice_allocator;
  localparam int N  = 4;
  localparam int TW = 24;

  logic            clk;
  logic            rst;
  logic            all_off;
  logic [N-1:0]    gate;
  logic [N*TW-1:0] ticks_flat;
  logic [N*7-1:0]  seg_flat;
  logic [4:0]      voice_count;
  logic            steal_pulse;

  int checks   = 0;
  int failures = 0;

  poly_voice_allocator_if evif ();

  poly_voice_allocator #(.NUM_VOICES(N), .TICK_W(TW), .AGE_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .all_off     (all_off),
    .ev          (evif),
    .gate        (gate),
    .ticks_flat  (ticks_flat),
    .seg_flat    (seg_flat),
    .voice_count (voice_count),
    .steal_pulse (steal_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    logic        brk;
    int          slot;
    logic [3:0]  gate;
    logic [10:0] tick;
    logic [6:0]  seg;
    logic [4:0]  cnt;
    logic        stl;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // Presents one event and counts edges from valid assertion until ev_ready returns.
  task automatic send(input logic [7:0] code, input logic brk, output int edges);
    int w;
    w = 0;
    while (!evif.ev_ready && w < 40) begin
      tick1();
      w++;
    end
    evif.ev_code  = code;
    evif.ev_break = brk;
    evif.ev_valid = 1'b1;
    edges = 0;
    do begin
      tick1();
      edges++;
      evif.ev_valid = 1'b0;
    end while (!evif.ev_ready && edges < 40);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_gate"},  32'(gate), 32'd0);
    chk({tag, "_count"}, 32'(voice_count), 32'd0);
    chk({tag, "_ticks_zero"}, 32'(|ticks_flat), 32'd0);
    chk({tag, "_seg_blank"},  32'(&seg_flat), 32'd1);
    chk({tag, "_ready"}, 32'(evif.ev_ready), 32'd1);
  endtask

  initial begin
    int e;
    int acc, first, second;

    vt[0] = '{8'h1C, 1'b0, 0, 4'b0001, 11'd1493, 7'b1000110, 5'd1, 1'b0};
    vt[1] = '{8'h1B, 1'b0, 1, 4'b0011, 11'd1330, 7'b0100001, 5'd2, 1'b0};
    vt[2] = '{8'h23, 1'b0, 2, 4'b0111, 11'd1185, 7'b0000110, 5'd3, 1'b0};
    vt[3] = '{8'h1B, 1'b1, 1, 4'b0101, 11'd0,    7'b1111111, 5'd2, 1'b0};
    vt[4] = '{8'h2B, 1'b0, 1, 4'b0111, 11'd1119, 7'b0001110, 5'd3, 1'b0};
    vt[5] = '{8'h1C, 1'b0, 0, 4'b0111, 11'd1493, 7'b1000110, 5'd3, 1'b0};
    vt[6] = '{8'h42, 1'b1, 2, 4'b0111, 11'd1185, 7'b0000110, 5'd3, 1'b0};
    vt[7] = '{8'h4C, 1'b0, 3, 4'b1111, 11'd593,  7'b0000110, 5'd4, 1'b0};
`ifdef VOICE_STEAL_EN
    // Slot 2 (E3) is the oldest gated voice once slot 0 was re-pressed.
    vt[8] = '{8'h34, 1'b0, 2, 4'b1111, 11'd996,  7'b1000010, 5'd4, 1'b1};
`else
    vt[8] = '{8'h34, 1'b0, 2, 4'b1111, 11'd1185, 7'b0000110, 5'd4, 1'b0};
`endif

    rst = 1'b1;
    all_off = 1'b0;
    evif.ev_valid = 1'b0;
    evif.ev_code  = 8'h00;
    evif.ev_break = 1'b0;
    repeat (3) tick1();
    rst = 1'b0;
    tick1();
    chk_cleared("reset");
    chk("reset_steal", 32'(steal_pulse), 32'd0);

    for (int i = 0; i < 9; i++) begin
      send(vt[i].code, vt[i].brk, e);
      chk($sformatf("v%0d_latency", i), 32'(e), 32'(N + 3));
      chk($sformatf("v%0d_gate", i), 32'(gate), 32'(vt[i].gate));
      chk($sformatf("v%0d_count", i), 32'(voice_count), 32'(vt[i].cnt));
      chk($sformatf("v%0d_tick", i), 32'(ticks_flat[vt[i].slot*TW +: TW]), 32'(vt[i].tick));
      chk($sformatf("v%0d_seg", i), 32'(seg_flat[vt[i].slot*7 +: 7]), 32'(vt[i].seg));
      chk($sformatf("v%0d_steal", i), 32'(steal_pulse), 32'(vt[i].stl));
    end
    tick1();
    chk("steal_one_cycle", 32'(steal_pulse), 32'd0);
    chk("slot0_untouched", 32'(ticks_flat[0 +: TW]), 32'd1493);

    // Continuous valid: one acceptance every N+3 cycles.
    evif.ev_code  = 8'h1C;
    evif.ev_break = 1'b0;
    evif.ev_valid = 1'b1;
    acc = 0; first = -1; second = -1;
    for (int c = 0; c < 3 * (N + 3); c++) begin
      if (evif.ev_ready) begin
        acc++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      tick1();
    end
    evif.ev_valid = 1'b0;
    chk("hold_accepts", 32'(acc), 32'd3);
    chk("hold_period", 32'(second - first), 32'(N + 3));
    chk("hold_gate", 32'(gate), 32'b1111);

    send(8'h76, 1'b0, e);
    chk("unmapped_latency", 32'(e), 32'd2);
    chk("unmapped_gate", 32'(gate), 32'b1111);
    chk("unmapped_count", 32'(voice_count), 32'd4);

    // all_off together with valid in IDLE: voices clear and the event is not taken.
    evif.ev_code  = 8'h1B;
    evif.ev_valid = 1'b1;
    all_off = 1'b1;
    tick1();
    evif.ev_valid = 1'b0;
    all_off = 1'b0;
    chk_cleared("alloff_idle");
    repeat (N + 4) tick1();
    chk("alloff_no_accept_gate", 32'(gate), 32'd0);

    send(8'h1C, 1'b0, e);
    send(8'h1B, 1'b0, e);
    send(8'h23, 1'b0, e);
    chk("three_gate", 32'(gate), 32'b0111);
    chk("three_count", 32'(voice_count), 32'd3);

    // all_off while the next press is mid-SCAN.
    evif.ev_code  = 8'h2B;
    evif.ev_break = 1'b0;
    evif.ev_valid = 1'b1;
    tick1();
    evif.ev_valid = 1'b0;
    tick1();
    tick1();
    chk("midscan_busy", 32'(evif.ev_ready), 32'd0);
    all_off = 1'b1;
    tick1();
    all_off = 1'b0;
    chk_cleared("alloff_scan");
    repeat (N + 4) tick1();
    chk("inflight_lost_gate", 32'(gate), 32'd0);
    chk("inflight_lost_count", 32'(voice_count), 32'd0);

    // Asynchronous reset while in COMMIT.
    send(8'h1C, 1'b0, e);
    chk("pre_rst_gate", 32'(gate), 32'b0001);
    evif.ev_code  = 8'h1B;
    evif.ev_valid = 1'b1;
    tick1();
    evif.ev_valid = 1'b0;
    repeat (N + 1) tick1();
    #1 rst = 1'b1;
    #1;
    chk_cleared("async_rst");
    #1 rst = 1'b0;
    repeat (N + 4) tick1();
    chk("post_rst_gate", 32'(gate), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
